sram_burst_master: RTL and testbench

- Avalon-MM initiator that drives the second port (s2) of the on-chip dual-port SRAM from the fabric side of the equation solver.
- On command, it either:
  - reads a contiguous run of 32-bit words and presents them on a valid/ready output stream (matrix row fetch), or
  - accepts a valid/ready input stream and writes it to a contiguous run of words (result write-back).
- The HPS accesses the same SRAM through port s1; this block does no arbitration with s1.

---
 rtl/sram_burst_master_pkg.sv | 20 ++
 rtl/sram_burst_rdfifo.sv | 69 ++++++
 rtl/sram_burst_master.sv | 154 +++++++++++++++
 tb/tb_sram_burst_master.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_burst_master_pkg.sv
// Shared definitions for the SRAM s2-side burst master and any s1-side logic
// that needs the same memory geometry.
//   SRAM_DATA_W   : SRAM word width in bits
//   SRAM_ADDR_W   : SRAM word-address width (depth = 2**SRAM_ADDR_W)
//   ST_*          : burst master FSM state encodings
//   burst_state_t : FSM state register type
package sram_burst_master_pkg;

  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_ADDR_W = 8;

  typedef logic [2:0] burst_state_t;

  localparam burst_state_t ST_IDLE     = 3'd0;
  localparam burst_state_t ST_RD_ISSUE = 3'd1;
  localparam burst_state_t ST_RD_DRAIN = 3'd2;
  localparam burst_state_t ST_WR       = 3'd3;
  localparam burst_state_t ST_FINISH   = 3'd4;

endpackage

// File: rtl/sram_burst_rdfifo.sv
// Read-return buffer for the SRAM burst master.
// Synchronous DEPTH x DATA_W FIFO with first-word-fall-through head.
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   push       : write push_data into the tail
//   push_data  : data to store
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry (valid when !empty)
//   count      : number of stored entries, 0..DEPTH
//   empty      : no entries stored
// A push together with a pop while full is legal and leaves count unchanged.
module sram_burst_rdfifo
  import sram_burst_master_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  // Explicit wrap so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_burst_master.sv
// Avalon-MM initiator on SRAM port s2 for the equation solver fabric.
// A command either streams a contiguous run of words out of the SRAM
// (read: mem -> rd_* stream) or writes an incoming stream into a contiguous
// run of words (write: wr_* stream -> mem). Addresses wrap modulo 2**ADDR_W.
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len : command handshake
//   rd_data/rd_valid/rd_ready/rd_last              : read output stream
//   wr_data/wr_valid/wr_ready                      : write input stream
//   mem_*                                          : registered s2 bus
//   busy : not IDLE     done : one-cycle completion pulse
// No arbitration with the HPS on port s1 is performed here.
module sram_burst_master
  import sram_burst_master_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int READ_LAT   = 2,
  // Must be at least READ_LAT+1 to sustain one word per cycle.
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ADDR_W:0]     cmd_len,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_last,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                busy,
  output logic                done
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LAT + 1);

  burst_state_t        state;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W-1:0]    remaining;  // words still to issue / accept
  logic [LEN_W-1:0]    rd_left;    // read beats still to hand over
  logic [READ_LAT-1:0] rd_vld_p;   // bit k: a read issued k+1 edges ago
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic [OCC_W-1:0]    occupancy;
  logic                rd_issue;
  logic                rd_push;
  logic                rd_pop;
  logic                wr_accept;

  function automatic logic [OCC_W-1:0] inflight_count(input logic [READ_LAT-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < READ_LAT; i++) n = n + OCC_W'(v[i]);
    return n;
  endfunction

  assign cmd_ready      = (state == ST_IDLE);
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_FINISH);
  assign wr_ready       = (state == ST_WR);
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;

  // Reads already in flight hold a FIFO slot, so the buffer can never overflow
  // even if the consumer stalls right after an issue.
  assign occupancy = OCC_W'(fifo_count) + inflight_count(rd_vld_p);
  assign rd_issue  = (state == ST_RD_ISSUE) && (remaining != '0) &&
                     (occupancy < OCC_W'(FIFO_DEPTH));
  assign wr_accept = wr_valid && wr_ready;
  assign rd_valid  = !fifo_empty;
  assign rd_pop    = rd_valid && rd_ready;
  assign rd_last   = rd_valid && (rd_left == LEN_W'(1));
  // readdata is unregistered in the SRAM, so it is valid in the cycle the
  // oldest in-flight bit is set and is captured at the following edge.
  assign rd_push   = rd_vld_p[READ_LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      addr           <= '0;
      remaining      <= '0;
      rd_left        <= '0;
      rd_vld_p       <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
    end else begin
      // Issue stage: bus outputs registered, in-flight tracking starts.
      rd_vld_p       <= (rd_vld_p << 1) | READ_LAT'(rd_issue);
      mem_chipselect <= rd_issue || wr_accept;
      mem_write      <= wr_accept;
      if (rd_issue || wr_accept) begin
        mem_address <= addr;
        addr        <= addr + ADDR_W'(1);
        remaining   <= remaining - LEN_W'(1);
      end
      if (wr_accept) mem_writedata <= wr_data;
      if (rd_pop)    rd_left       <= rd_left - LEN_W'(1);

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
            rd_left   <= cmd_write ? '0 : cmd_len;
            if (cmd_len == '0)  state <= ST_FINISH;
            else if (cmd_write) state <= ST_WR;
            else                state <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: begin
          if (rd_issue && (remaining == LEN_W'(1))) state <= ST_RD_DRAIN;
        end
        ST_RD_DRAIN: begin
          if (rd_pop && (rd_left == LEN_W'(1))) state <= ST_FINISH;
        end
        ST_WR: begin
          if (wr_accept && (remaining == LEN_W'(1))) state <= ST_FINISH;
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Return stage: captured readdata queued for the output stream.
  sram_burst_rdfifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_push),
    .push_data (mem_readdata),
    .pop       (rd_pop),
    .head      (rd_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_sram_burst_master.sv
module tb_sram_burst_master;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int READ_LAT   = 2;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [7:0]        cmd_addr;
  logic [8:0]        cmd_len;
  logic [31:0]       rd_data;
  logic              rd_valid, rd_ready, rd_last;
  logic [31:0]       wr_data;
  logic              wr_valid, wr_ready;
  logic [7:0]        mem_address;
  logic              mem_chipselect, mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata;
  logic              busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_burst_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .busy(busy), .done(done)
  );

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return {8'h5A, a, 8'h3C, ~a};
  endfunction

  // SRAM port s2 device: registered address, unregistered readdata.
  logic [31:0] sram [256];
  logic [7:0]  sram_addr_q;
  bit          fill;
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_word(8'(i));
    end else if (mem_clken) begin
      if (mem_chipselect && mem_write) sram[mem_address] <= mem_writedata;
    end
    sram_addr_q <= mem_address;
  end
  assign mem_readdata = sram[sram_addr_q];

  // Bus activity counters.
  int cs_cnt = 0, wbus_cnt = 0, done_cnt = 0;
  always @(posedge clk) begin
    if (mem_chipselect)              cs_cnt   <= cs_cnt + 1;
    if (mem_chipselect && mem_write) wbus_cnt <= wbus_cnt + 1;
    if (done)                        done_cnt <= done_cnt + 1;
  end

  // Reference memory contents expected after every completed write.
  logic [31:0] model [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dmode 0: data 0xA0+i, 1: random.  gaps: randomly drop wr_valid.
  task automatic wr_cmd(input logic [7:0] a, input int l, input int dmode, input bit gaps);
    int i, cyc, d0;
    bit acc;
    logic [7:0]  ea;
    logic [31:0] ed;
    d0 = done_cnt;
    chk("wr_cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_len = 9'(l);
    tick();
    cmd_valid = 0;
    i = 0; cyc = 0; ea = '0; ed = '0;
    while (i < l && cyc < 400) begin
      wr_data  = (dmode == 0) ? (32'hA0 + 32'(i)) : $urandom;
      wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      acc = wr_valid && wr_ready;
      if (acc) begin
        ea = a + 8'(i);
        ed = wr_data;
        model[ea] = ed;
        i++;
      end
      tick();
      cyc++;
      if (acc) begin
        chk("wr_bus_we", mem_write, 1);
        chk("wr_bus_cs", mem_chipselect, 1);
        chk("wr_bus_addr", mem_address, ea);
        chk("wr_bus_data", mem_writedata, ed);
      end else begin
        chk("wr_idle_we", mem_write, 0);
      end
    end
    wr_valid = 0;
    chk("wr_timeout", i, l);
    chk("wr_done", done, 1);
    chk("wr_busy_fin", busy, 1);
    tick();
    chk("wr_done_clr", done, 0);
    chk("wr_busy_clr", busy, 0);
    chk("wr_done_cnt", done_cnt - d0, 1);
  endtask

  // rmode 0: rd_ready high, 1: pattern 1,0,0,1,0,0..., 2: random.
  task automatic rd_cmd(input logic [7:0] a, input int l, input int rmode, input bit chk_lat);
    int beats, cyc, first, lastc, d0, w0;
    bit stalled;
    logic [31:0] held;
    logic [7:0]  ea;
    d0 = done_cnt; w0 = wbus_cnt;
    chk("rd_cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = 0; cmd_addr = a; cmd_len = 9'(l);
    tick();
    cmd_valid = 0;
    chk("rd_busy_no_cmd_ready", cmd_ready, 0);
    beats = 0; cyc = 0; first = -1; lastc = -1; stalled = 0; held = '0;
    while (beats < l && cyc < 2000) begin
      if (stalled) begin
        chk("rd_hold_valid", rd_valid, 1);
        chk("rd_hold_data", rd_data, held);
      end
      case (rmode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 3 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      chk("rd_fifo_bound", int'(dut.u_fifo.count) <= FIFO_DEPTH, 1);
      chk("rd_wr_ready_low", wr_ready, 0);
      if (rd_valid && rd_ready) begin
        ea = a + 8'(beats);
        chk("rd_data", rd_data, model[ea]);
        chk("rd_last", rd_last, (beats == l - 1));
        if (first < 0) first = cyc;
        lastc = cyc;
        beats++;
      end
      stalled = rd_valid && !rd_ready;
      held = rd_data;
      tick();
      cyc++;
    end
    rd_ready = 0;
    chk("rd_timeout", beats, l);
    if (chk_lat) begin
      chk("rd_first_lat", first, 3);
      chk("rd_back_to_back", lastc - first, l - 1);
    end
    chk("rd_done", done, 1);
    chk("rd_busy_fin", busy, 1);
    chk("rd_valid_fin", rd_valid, 0);
    tick();
    chk("rd_done_clr", done, 0);
    chk("rd_busy_clr", busy, 0);
    chk("rd_done_cnt", done_cnt - d0, 1);
    chk("rd_no_bus_write", wbus_cnt - w0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0, w0;
    logic [7:0] ra;
    int rl;
    reset = 1; fill = 1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    rd_ready = 0; wr_data = '0; wr_valid = 0;
    for (int i = 0; i < 256; i++) model[i] = init_word(8'(i));
    tick(); tick();
    chk("rst_we", mem_write, 0);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_writedata, 0);
    #3 reset = 0; fill = 0;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("byteenable", mem_byteenable, 4'hF);
    chk("clken", mem_clken, 1);

    // Basic write then readback.
    wr_cmd(8'h10, 4, 0, 0);
    rd_cmd(8'h10, 4, 0, 1);

    // Read 8 with rd_ready high; stray wr_valid must not be accepted.
    wr_valid = 1;
    rd_cmd(8'h00, 8, 0, 1);
    wr_valid = 0;

    // Backpressured read.
    rd_cmd(8'h20, 6, 1, 0);

    // Address wrap.
    wr_cmd(8'hFE, 3, 1, 0);
    rd_cmd(8'hFE, 3, 0, 1);

    // Zero-length command.
    c0 = cs_cnt; d0 = done_cnt;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h40; cmd_len = '0;
    tick();
    cmd_valid = 0;
    chk("len0_done", done, 1);
    tick();
    chk("len0_done_clr", done, 0);
    chk("len0_idle", cmd_ready, 1);
    chk("len0_no_cs", cs_cnt - c0, 0);
    chk("len0_done_cnt", done_cnt - d0, 1);

    // Randomized write/read pairs.
    for (int k = 0; k < 4; k++) begin
      ra = 8'($urandom);
      rl = $urandom_range(1, 12);
      wr_cmd(ra, rl, 1, 1);
      rd_cmd(ra - 8'd1, rl + 2, 2, 0);
    end

    // Whole-memory read.
    rd_cmd(8'h00, 256, 0, 1);

    // Reset during the third of five write beats.
    w0 = wbus_cnt;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h80; cmd_len = 9'd5;
    tick();
    cmd_valid = 0;
    wr_valid = 1; wr_data = 32'hD000_0000;
    tick();
    model[8'h80] = 32'hD000_0000;
    wr_data = 32'hD000_0001;
    tick();
    model[8'h81] = 32'hD000_0001;
    wr_data = 32'hD000_0002;
    tick();
    chk("rstmid_third_on_bus", mem_write, 1);
    chk("rstmid_third_addr", mem_address, 8'h82);
    #2 reset = 1;
    #1;
    chk("rstmid_we_drop", mem_write, 0);
    chk("rstmid_cs_drop", mem_chipselect, 0);
    chk("rstmid_wr_ready", wr_ready, 0);
    wr_valid = 0;
    @(posedge clk);
    #3 reset = 0;
    tick();
    chk("rstmid_cmd_ready", cmd_ready, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rd_valid", rd_valid, 0);
    chk("rstmid_bus_writes", wbus_cnt - w0, 2);
    rd_cmd(8'h80, 5, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
